// File: rtl/cmos_pwr_seq_pkg.sv
// Shared state encodings, timing defaults and output bundle for the
// camera power-up sequencer.
package cmos_seq_pkg;

    localparam logic [2:0] S_WAIT_LOCK = 3'd0;
    localparam logic [2:0] S_PWDN_REL  = 3'd1;
    localparam logic [2:0] S_RST_REL   = 3'd2;
    localparam logic [2:0] S_READY     = 3'd3;

    // Defaults assume the 24 MHz camera clock: 1 ms and 20 ms gaps.
    localparam int DEF_CNT_W           = 20;
    localparam int DEF_LOCK_STABLE_CYC = 1024;
    localparam int DEF_T_PWDN_CYC      = 24000;
    localparam int DEF_T_INIT_CYC      = 480000;

    typedef struct packed {
        logic pwdn;
        logic rst_n;
        logic init_start;
        logic seq_done;
    } seq_out_t;

    localparam seq_out_t SAFE_OUT = '{
        pwdn:       1'b1,
        rst_n:      1'b0,
        init_start: 1'b0,
        seq_done:   1'b0
    };

endpackage

// File: rtl/cmos_pwr_seq_if.sv
// Sensor-side control and status bundle of the power-up sequencer.
interface cmos_pwr_seq_if;
    import cmos_seq_pkg::*;

    logic       pll_lock;
    logic       restart;
    logic       cmos_pwdn;
    logic       cmos_rst_n;
    logic       init_start;
    logic       seq_done;
    logic [2:0] seq_state;

    modport master (
        output pll_lock, restart,
        input  cmos_pwdn, cmos_rst_n, init_start, seq_done, seq_state
    );

    modport slave (
        input  pll_lock, restart,
        output cmos_pwdn, cmos_rst_n, init_start, seq_done, seq_state
    );

endinterface

// File: rtl/cmos_pwr_seq_sync2.sv
// Two-flop synchronizer, asynchronously reset to 0.
module cmos_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cmos_pwr_seq.sv
// Camera power-up sequencer: PLL lock qualification, PWDN/RESET release
// with fixed dwell gaps, then a one-shot init_start to the SCCB config block.
module cmos_pwr_seq
    import cmos_seq_pkg::*;
#(
    parameter int CNT_W           = DEF_CNT_W,
    parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
    parameter int T_PWDN_CYC      = DEF_T_PWDN_CYC,
    parameter int T_INIT_CYC      = DEF_T_INIT_CYC
) (
    input  logic           clk,
    input  logic           reset,
    cmos_pwr_seq_if.slave  bus
);

    localparam longint CNT_SPAN = longint'(1) << CNT_W;
    localparam bit PARAM_OK =
        LOCK_STABLE_CYC >= 1 && longint'(LOCK_STABLE_CYC) <= CNT_SPAN &&
        T_PWDN_CYC >= 1      && longint'(T_PWDN_CYC) <= CNT_SPAN &&
        T_INIT_CYC >= 1      && longint'(T_INIT_CYC) <= CNT_SPAN;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] PWDN_LAST = CNT_W'(T_PWDN_CYC - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(T_INIT_CYC - 1);

    logic             lock_s;
    logic             abort;
    logic [2:0]       state;
    logic [2:0]       nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    seq_out_t         out_q;
    seq_out_t         out_d;

    cmos_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.pll_lock),
        .q     (lock_s)
    );

    assign abort = bus.restart || !lock_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
            out_q <= SAFE_OUT;
        end else begin
            state <= nxt;
            cnt   <= cnt_d;
            out_q <= out_d;
        end
    end

    // Abort is tested before dwell expiry so it always wins.
    always_comb begin
        nxt = S_WAIT_LOCK;
        case (state)
            S_WAIT_LOCK:
                if (!abort && cnt == LOCK_LAST) nxt = S_PWDN_REL;
            S_PWDN_REL:
                if (abort)                  nxt = S_WAIT_LOCK;
                else if (cnt == PWDN_LAST)  nxt = S_RST_REL;
                else                        nxt = S_PWDN_REL;
            S_RST_REL:
                if (abort)                  nxt = S_WAIT_LOCK;
                else if (cnt == INIT_LAST)  nxt = S_READY;
                else                        nxt = S_RST_REL;
            S_READY:
                if (!abort)                 nxt = S_READY;
            default:
                nxt = S_WAIT_LOCK;
        endcase
    end

    // Dwell counter restarts on every state entry and saturates.
    always_comb begin
        cnt_d = cnt;
        if (nxt != state || (state == S_WAIT_LOCK && abort))
            cnt_d = '0;
        else if (cnt != '1)
            cnt_d = cnt + CNT_W'(1);
    end

    always_comb begin
        out_d            = SAFE_OUT;
        out_d.pwdn       = (nxt == S_WAIT_LOCK);
        out_d.rst_n      = (nxt == S_RST_REL) || (nxt == S_READY);
        out_d.seq_done   = (nxt == S_READY);
        out_d.init_start = (nxt == S_READY) && (state == S_RST_REL);
    end

    assign bus.cmos_pwdn  = out_q.pwdn;
    assign bus.cmos_rst_n = out_q.rst_n;
    assign bus.init_start = out_q.init_start;
    assign bus.seq_done   = out_q.seq_done;
    assign bus.seq_state  = state;

    param_ok_a: assert property (@(posedge clk) PARAM_OK)
        else $error("cmos_pwr_seq: a *_CYC parameter is out of range");

endmodule

// File: tb/tb_cmos_pwr_seq.sv
// Directed bench for cmos_pwr_seq with short dwell parameters (4/3/5).
module tb_cmos_pwr_seq;
    import cmos_seq_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic prev_init = 1'b0;
    logic [6:0] obs;

    always #5 clk = ~clk;

    cmos_pwr_seq_if bus ();

    cmos_pwr_seq #(
        .CNT_W           (20),
        .LOCK_STABLE_CYC (4),
        .T_PWDN_CYC      (3),
        .T_INIT_CYC      (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign obs = {bus.seq_state, bus.cmos_pwdn, bus.cmos_rst_n,
                  bus.init_start, bus.seq_done};

    // Expected {state, pwdn, rst_n, init_start, seq_done} for a state
    // and the state held one edge earlier.
    function automatic logic [6:0] exp_out(input logic [2:0] st,
                                           input logic [2:0] pst);
        return {st, st == S_WAIT_LOCK,
                st == S_RST_REL || st == S_READY,
                st == S_READY && pst == S_RST_REL,
                st == S_READY};
    endfunction

    // Advance one edge, sample 1 time unit later, check global invariants.
    task automatic tick();
        @(posedge clk);
        #1;
        n_assert += 2;
        if (bus.cmos_rst_n && bus.cmos_pwdn) begin
            n_fail++;
            $display("FAIL rst_n_implies_pwdn_low: pwdn=%b rst_n=%b required pwdn=0",
                     bus.cmos_pwdn, bus.cmos_rst_n);
        end
        if (bus.init_start && prev_init) begin
            n_fail++;
            $display("FAIL init_start_one_cycle: high 2 cycles, required single pulse");
        end
        prev_init = bus.init_start;
    endtask

    task automatic do_reset(input logic lock);
        reset        = 1'b1;
        bus.restart  = 1'b0;
        bus.pll_lock = lock;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.restart  = 1'b0;
        bus.pll_lock = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_assert++;
            if (obs !== 7'b000_1000) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %b required %b",
                         k, obs, 7'b000_1000);
            end
        end
    endtask

    // Lock high out of reset: pwdn falls edge 6, rst_n edge 9, init edge 14.
    task automatic test_nominal();
        logic [2:0] st;
        logic [2:0] pst;
        do_reset(1'b1);
        pst = S_WAIT_LOCK;
        for (int k = 1; k <= 20; k++) begin
            tick();
            st = (k < 6) ? S_WAIT_LOCK : (k < 9) ? S_PWDN_REL :
                 (k < 14) ? S_RST_REL : S_READY;
            n_assert++;
            if (obs !== exp_out(st, pst)) begin
                n_fail++;
                $display("FAIL nominal edge %0d: got %b required %b",
                         k, obs, exp_out(st, pst));
            end
            pst = st;
        end
    endtask

    // Lock sampled 1,1,1,0,1...: the count reaches 3 then clears, so
    // pwdn only falls 4 stable synced cycles after the re-rise (edge 10).
    task automatic test_lock_glitch();
        logic [2:0] st;
        logic [2:0] pst;
        do_reset(1'b0);
        bus.pll_lock = 1'b1;
        pst = S_WAIT_LOCK;
        for (int k = 1; k <= 12; k++) begin
            tick();
            st = (k < 10) ? S_WAIT_LOCK : S_PWDN_REL;
            n_assert++;
            if (obs !== exp_out(st, pst)) begin
                n_fail++;
                $display("FAIL lock_glitch edge %0d: got %b required %b",
                         k, obs, exp_out(st, pst));
            end
            pst = st;
            if (k == 3) bus.pll_lock = 1'b0;
            if (k == 4) bus.pll_lock = 1'b1;
        end
    endtask

    // Lock drop first sampled at edge 11 (2nd dwell cycle); abort 2 edges
    // later at 13. Lock returns sampled at edge 14: rerun 19/22/27.
    task automatic test_lock_loss();
        logic [2:0] st;
        logic [2:0] pst;
        do_reset(1'b1);
        pst = S_WAIT_LOCK;
        for (int k = 1; k <= 30; k++) begin
            tick();
            st = (k < 6)  ? S_WAIT_LOCK : (k < 9)  ? S_PWDN_REL :
                 (k < 13) ? S_RST_REL   : (k < 19) ? S_WAIT_LOCK :
                 (k < 22) ? S_PWDN_REL  : (k < 27) ? S_RST_REL : S_READY;
            n_assert++;
            if (obs !== exp_out(st, pst)) begin
                n_fail++;
                $display("FAIL lock_loss edge %0d: got %b required %b",
                         k, obs, exp_out(st, pst));
            end
            pst = st;
            if (k == 10) bus.pll_lock = 1'b0;
            if (k == 13) bus.pll_lock = 1'b1;
        end
    endtask

    // From S_READY, a 1-cycle restart aborts on the next edge and the
    // sequence reruns with lock already synced: 5 / 8 / 13.
    task automatic test_restart();
        logic [2:0] st;
        logic [2:0] pst;
        int         pulses;
        pst    = S_READY;
        pulses = 0;
        bus.restart = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            bus.restart = 1'b0;
            st = (k < 5) ? S_WAIT_LOCK : (k < 8) ? S_PWDN_REL :
                 (k < 13) ? S_RST_REL : S_READY;
            n_assert++;
            if (obs !== exp_out(st, pst)) begin
                n_fail++;
                $display("FAIL restart edge %0d: got %b required %b",
                         k, obs, exp_out(st, pst));
            end
            if (bus.init_start) pulses++;
            pst = st;
        end
        n_assert++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL restart_init_count: got %0d pulses required 1", pulses);
        end
    endtask

    // Restart sampled on edge 9 together with PWDN dwell expiry.
    task automatic test_simultaneous();
        logic [2:0] st;
        logic [2:0] pst;
        do_reset(1'b1);
        pst = S_WAIT_LOCK;
        for (int k = 1; k <= 15; k++) begin
            tick();
            st = (k < 6) ? S_WAIT_LOCK : (k < 9) ? S_PWDN_REL :
                 (k < 13) ? S_WAIT_LOCK : S_PWDN_REL;
            n_assert++;
            if (obs !== exp_out(st, pst)) begin
                n_fail++;
                $display("FAIL simultaneous edge %0d: got %b required %b",
                         k, obs, exp_out(st, pst));
            end
            pst = st;
            if (k == 8) bus.restart = 1'b1;
            if (k == 9) bus.restart = 1'b0;
        end
    endtask

    initial begin
        bus.pll_lock = 1'b1;
        bus.restart  = 1'b0;
        test_reset();
        test_nominal();
        test_lock_glitch();
        test_lock_loss();
        test_restart();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
